// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I R/I/S fields into 32-bit words and
// streams them into instruction memory at consecutive word addresses.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clear             sync restart: address to BASE_ADDR, drop pending, zero counts
//   in_valid/ready    field-set handshake
//   fmt               0=R 1=I 2=S 3=illegal
//   opcode..imm       decoded instruction fields
//   imem_we/ready     IMEM write handshake (we held until ready)
//   imem_addr/wdata   registered write address / encoded word
//   err_valid/code    one-cycle reject pulse, sticky code (1=fmt 2=imm range)
//   wr_count          words committed to IMEM
//   full              committed + pending reached DEPTH (sticky until rst/clear)
module instr_encoder #(
  parameter int INSTRUCTION = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             fmt,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [2:0]             funct3,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [6:0]             funct7,
  input  logic [INSTRUCTION-1:0] imm,
  output logic                   imem_we,
  input  logic                   imem_ready,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [INSTRUCTION-1:0] imem_wdata,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [ADDR_W:0]        wr_count,
  output logic                   full
);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_S = 2'd2;

  localparam logic [1:0] ERR_FMT = 2'd1;
  localparam logic [1:0] ERR_IMM = 2'd2;

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic                   we_q,    we_d;
  logic [ADDR_W-1:0]      addr_q,  addr_d;
  logic [INSTRUCTION-1:0] wdata_q, wdata_d;
  logic                   errv_q,  errv_d;
  logic [1:0]             errc_q,  errc_d;
  logic [ADDR_W:0]        cnt_q,   cnt_d;
  logic [ADDR_W:0]        occ_q,   occ_d;
  logic                   full_q,  full_d;

  logic [INSTRUCTION-12:0] imm_hi;
  logic                    imm_ok;
  logic [INSTRUCTION-1:0]  enc;
  logic                    bad;
  logic [1:0]              code;
  logic                    acc;
  logic                    commit;

  // 12-bit signed immediate: bits [MSB:11] must be a pure sign extension.
  assign imm_hi = imm[INSTRUCTION-1:11];
  assign imm_ok = (&imm_hi) || !(|imm_hi);

  always_comb begin
    enc  = '0;
    bad  = 1'b0;
    code = 2'd0;
    unique case (fmt)
      FMT_R: begin
        enc = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        enc = {imm[11:0], rs1, funct3, rd, opcode};
        if (!imm_ok) begin
          bad  = 1'b1;
          code = ERR_IMM;
        end
      end
      FMT_S: begin
        enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!imm_ok) begin
          bad  = 1'b1;
          code = ERR_IMM;
        end
      end
      default: begin
        bad  = 1'b1;
        code = ERR_FMT;
      end
    endcase
  end

  // One-deep output register: a new word may load on the edge
  // that retires the current one.
  assign in_ready = !full_q && (!we_q || imem_ready);
  assign acc      = in_valid && in_ready;
  assign commit   = we_q && imem_ready;

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    errv_d  = 1'b0;
    errc_d  = errc_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    if (commit) begin
      we_d   = 1'b0;
      addr_d = addr_q + ONE_A;
      cnt_d  = cnt_q + ONE_C;
    end
    if (acc) begin
      if (bad) begin
        errv_d = 1'b1;
        errc_d = code;
      end else begin
        we_d    = 1'b1;
        wdata_d = enc;
        occ_d   = occ_q + ONE_C;
      end
    end
    // occ only grows, so full stays set until rst/clear.
    full_d = (occ_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      we_q    <= 1'b0;
      addr_q  <= BASE_C;
      wdata_q <= '0;
      errv_q  <= 1'b0;
      errc_q  <= 2'd0;
      cnt_q   <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      errv_q  <= errv_d;
      errc_q  <= errc_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err_valid  = errv_q;
  assign err_code   = errc_q;
  assign wr_count   = cnt_q;
  assign full       = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed bench for instr_encoder (DEPTH=4).
// Scenario tasks with inline checks, one summary line.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        imem_we, imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [8:0]  wr_count;
  logic        full;

  int checks = 0;
  int failures = 0;
  logic [31:0] sx;

  always #5 clk = ~clk;

  instr_encoder #(
    .INSTRUCTION(32), .ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_valid(err_valid), .err_code(err_code),
    .wr_count(wr_count), .full(full)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [1:0] f, input logic [6:0] op,
                       input logic [4:0] d, input logic [2:0] f3,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; funct3 = f3;
    rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic set_r;
    set_f(2'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", imem_we); end
    checks++; if (imem_addr !== 8'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL rst_err got=%0b/%0d exp=0/0", err_valid, err_code); end
    checks++; if (wr_count !== 9'd0 || full !== 1'b0) begin failures++; $display("FAIL rst_cnt got=%0d/%0b exp=0/0", wr_count, full); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%0b exp=1", in_ready); end
  endtask

  task automatic test_r_type;
    imem_ready = 1'b1;
    set_r; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin failures++; $display("FAIL r_we got=%0b exp=1", imem_we); end
    checks++; if (imem_addr !== 8'd0) begin failures++; $display("FAIL r_addr got=%0d exp=0", imem_addr); end
    checks++; if (imem_wdata !== 32'h002081B3) begin failures++; $display("FAIL r_wdata got=%h exp=002081b3", imem_wdata); end
    checks++; if (wr_count !== 9'd0) begin failures++; $display("FAIL r_cnt0 got=%0d exp=0", wr_count); end
    tick;
    checks++; if (imem_we !== 1'b0 || wr_count !== 9'd1 || imem_addr !== 8'd1) begin
      failures++; $display("FAIL r_commit got we=%0b cnt=%0d addr=%0d exp 0/1/1", imem_we, wr_count, imem_addr); end
  endtask

  task automatic test_i_backpressure;
    imem_ready = 1'b0;
    set_f(2'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (imem_wdata !== 32'hFFF00293 || imem_addr !== 8'd1) begin
      failures++; $display("FAIL i_word got=%h@%0d exp=fff00293@1", imem_wdata, imem_addr); end
    sx = {{20{imem_wdata[31]}}, imem_wdata[31:20]};
    checks++; if (sx !== 32'hFFFFFFFF) begin failures++; $display("FAIL i_roundtrip got=%h exp=ffffffff", sx); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'hFFF00293 || imem_addr !== 8'd1) begin
        failures++; $display("FAIL bp_stable%0d got we=%0b %h@%0d", i, imem_we, imem_wdata, imem_addr); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy%0d got=%0b exp=0", i, in_ready); end
      tick;
    end
    imem_ready = 1'b1;
    tick;
    checks++; if (wr_count !== 9'd2 || imem_addr !== 8'd2 || imem_we !== 1'b0) begin
      failures++; $display("FAIL bp_commit got cnt=%0d addr=%0d we=%0b exp 2/2/0", wr_count, imem_addr, imem_we); end
  endtask

  task automatic test_back_to_back;
    imem_ready = 1'b1;
    set_f(2'd2, 7'h23, 5'd31, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    in_valid = 1'b1;
    tick;
    checks++; if (imem_wdata !== 32'h0020A423 || imem_addr !== 8'd2) begin
      failures++; $display("FAIL s8_word got=%h@%0d exp=0020a423@2", imem_wdata, imem_addr); end
    set_f(2'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy got=%0b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'hFE20AE23 || imem_addr !== 8'd3) begin
      failures++; $display("FAIL s4_word got we=%0b %h@%0d exp 1 fe20ae23@3", imem_we, imem_wdata, imem_addr); end
    checks++; if (wr_count !== 9'd3) begin failures++; $display("FAIL b2b_cnt got=%0d exp=3", wr_count); end
    sx = {{20{imem_wdata[31]}}, imem_wdata[31:25], imem_wdata[11:7]};
    checks++; if (sx !== 32'hFFFFFFFC) begin failures++; $display("FAIL s_roundtrip got=%h exp=fffffffc", sx); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_pend got=%0b exp=1", full); end
    tick;
    checks++; if (wr_count !== 9'd4 || full !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full4 got cnt=%0d full=%0b rdy=%0b exp 4/1/0", wr_count, full, in_ready); end
  endtask

  task automatic test_full_block;
    set_r; in_valid = 1'b1;
    tick; tick;
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b0 || wr_count !== 9'd4 || imem_addr !== 8'd4) begin
      failures++; $display("FAIL full_blk got we=%0b cnt=%0d addr=%0d exp 0/4/4", imem_we, wr_count, imem_addr); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_hold got=%0b exp=1", full); end
  endtask

  task automatic test_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++; if (full !== 1'b0 || wr_count !== 9'd0 || imem_addr !== 8'd0) begin
      failures++; $display("FAIL clr got full=%0b cnt=%0d addr=%0d exp 0/0/0", full, wr_count, imem_addr); end
    imem_ready = 1'b0;
    set_r; in_valid = 1'b1;
    tick;
    checks++; if (imem_we !== 1'b1) begin failures++; $display("FAIL clr_pend got=%0b exp=1", imem_we); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0 || wr_count !== 9'd0 || imem_wdata !== 32'h0) begin
      failures++; $display("FAIL clr_drop got we=%0b addr=%0d cnt=%0d wd=%h", imem_we, imem_addr, wr_count, imem_wdata); end
    imem_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h002081B3) begin
      failures++; $display("FAIL clr_resume got we=%0b %h@%0d", imem_we, imem_wdata, imem_addr); end
    tick;
    checks++; if (wr_count !== 9'd1 || imem_addr !== 8'd1) begin
      failures++; $display("FAIL clr_commit got cnt=%0d addr=%0d exp 1/1", wr_count, imem_addr); end
  endtask

  task automatic test_errors;
    imem_ready = 1'b1;
    set_f(2'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800);
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL err_rdy got=%0b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd2) begin
      failures++; $display("FAIL err_imm got=%0b/%0d exp=1/2", err_valid, err_code); end
    checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd1) begin
      failures++; $display("FAIL err_nowr got we=%0b addr=%0d exp 0/1", imem_we, imem_addr); end
    tick;
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd2) begin
      failures++; $display("FAIL err_hold got=%0b/%0d exp=0/2", err_valid, err_code); end
    set_f(2'd3, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd1) begin
      failures++; $display("FAIL err_fmt got=%0b/%0d exp=1/1", err_valid, err_code); end
    set_f(2'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'hFFFFF7FF);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd2 || imem_we !== 1'b0) begin
      failures++; $display("FAIL err_s got=%0b/%0d we=%0b exp=1/2/0", err_valid, err_code, imem_we); end
    set_f(2'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF800);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (err_valid !== 1'b0 || imem_we !== 1'b1 || imem_wdata !== 32'h80000093 || imem_addr !== 8'd1) begin
      failures++; $display("FAIL imm_min got err=%0b we=%0b %h@%0d exp 0 1 80000093@1", err_valid, imem_we, imem_wdata, imem_addr); end
    tick;
    checks++; if (wr_count !== 9'd2 || imem_addr !== 8'd2) begin
      failures++; $display("FAIL imm_min_commit got cnt=%0d addr=%0d exp 2/2", wr_count, imem_addr); end
  endtask

  task automatic test_reset_mid;
    imem_ready = 1'b0;
    set_r; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd2) begin
      failures++; $display("FAIL rm_pend got we=%0b addr=%0d exp 1/2", imem_we, imem_addr); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0 || wr_count !== 9'd0 || err_code !== 2'd0) begin
      failures++; $display("FAIL rm_reset got we=%0b addr=%0d cnt=%0d ec=%0d", imem_we, imem_addr, wr_count, err_code); end
    imem_ready = 1'b1;
    set_r; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h002081B3) begin
      failures++; $display("FAIL rm_resume got we=%0b %h@%0d", imem_we, imem_wdata, imem_addr); end
    tick;
    checks++; if (wr_count !== 9'd1) begin failures++; $display("FAIL rm_commit got=%0d exp=1", wr_count); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    set_f(2'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    #2;
    test_reset;
    test_r_type;
    test_i_backpressure;
    test_back_to_back;
    test_full_block;
    test_clear;
    test_errors;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
